cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter s_way, default 1, log2 of associativity (num_way = 2**s_way).
REQ-002 Parameter s_index, default 3, log2 of set count; forwarded for consistency with the datapath.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_read  input  1  CPU read request; held until mem_resp.
REQ-006 mem_write  input  1  CPU write request; held until mem_resp; never asserted together with mem_read.
REQ-007 hit  input  num_way  per-way tag match AND valid for the addressed set.
REQ-008 victim_valid  input  1  valid bit of the way selected by lru_way.
REQ-009 victim_dirty  input  1  dirty bit of the way selected by lru_way.
REQ-010 lru_way  input  s_way  replacement way from the PLRU tracker.
REQ-011 pmem_resp  input  1  physical memory completion, one-cycle pulse.
REQ-012 mem_resp  output  1  CPU completion pulse.
REQ-013 pmem_read  output  1  line-fill request to physical memory.
REQ-014 pmem_write  output  1  line-writeback request to physical memory.
REQ-015 pmem_addr_sel  output  1  0 = CPU address, 1 = victim tag address.
REQ-016 way_sel  output  s_way  way addressed by datapath writes.
REQ-017 load_data  output  1  write line array at way_sel (fill or CPU write).
REQ-018 data_src  output  1  0 = pmem line, 1 = CPU write data merged by byte enable.
REQ-019 load_tag  output  1  write tag, set valid, at way_sel.
REQ-020 set_dirty  output  1  set dirty bit at way_sel.
REQ-021 clr_dirty  output  1  clear dirty bit at way_sel.
REQ-022 lru_update  output  1  hit pulse to PLRU (drives its hit/read inputs) with way = way_sel.
REQ-023 hit_count  output  32  saturating count of requests completed without a miss.
REQ-024 miss_count  output  32  saturating count of misses.

Function
REQ-025 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE; one state register, Moore outputs except where stated.
REQ-026 IDLE: all outputs 0; mem_read|mem_write -> COMPARE next cycle.
REQ-027 COMPARE with hit != 0: mem_resp=1, lru_update=1, way_sel = lowest-index set bit of hit, -> IDLE.
REQ-028 COMPARE hit on write: additionally load_data=1, data_src=1, set_dirty=1, same cycle.
REQ-029 COMPARE hit increments hit_count unless the request is a post-fill recheck (REQ-034).
REQ-030 COMPARE miss (hit == 0): latch victim = lru_way into register; miss_count +1; -> WRITEBACK if victim_valid & victim_dirty, else -> ALLOCATE.
REQ-031 WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim; hold until pmem_resp; on pmem_resp -> ALLOCATE.
REQ-032 ALLOCATE: pmem_read=1, pmem_addr_sel=0, way_sel=victim; hold until pmem_resp.
REQ-033 ALLOCATE with pmem_resp: load_data=1, data_src=0, load_tag=1, clr_dirty=1 in that cycle; -> COMPARE.
REQ-034 A recheck flag is set on ALLOCATE exit and cleared on leaving COMPARE; recheck COMPARE completes the request (mem_resp) without incrementing hit_count.
REQ-035 Miss latency, clean victim: mem_resp = 2 cycles + fill wait + 1 after request; dirty adds writeback wait.
REQ-036 pmem_read and pmem_write never asserted in the same cycle.
REQ-037 victim latched once per miss; lru_way changes during WRITEBACK/ALLOCATE ignored.
REQ-038 CPU request deasserted mid-miss: refill still completes; recheck COMPARE with no request -> IDLE with no mem_resp.
REQ-039 hit == 0 in recheck COMPARE (datapath fault): treated as a new miss per REQ-030.
REQ-040 pmem_resp in IDLE or COMPARE ignored.
REQ-041 Counters saturate at 32'hFFFF_FFFF, no wrap.

Reset
REQ-042 rst: state=IDLE, victim=0, recheck=0, hit_count=0, miss_count=0; all outputs 0 the cycle after the rst edge.
REQ-043 rst mid-WRITEBACK/ALLOCATE aborts the transfer; pmem lines low next cycle; no tag/data write.

Verification
REQ-044 Read hit way 1 (hit=2'b10) -> COMPARE next cycle: mem_resp=1, lru_update=1, way_sel=1; hit_count=1.
REQ-045 Write miss, lru_way=0, victim clean -> ALLOCATE, pmem_read=1 until pmem_resp at cycle 5; fill cycle load_tag=1, clr_dirty=1; recheck hit then mem_resp, load_data=1, data_src=1, set_dirty=1; miss_count=1, hit_count=0.
REQ-046 Read miss, victim dirty, lru_way=1 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1, way_sel=1; pmem_resp -> ALLOCATE, pmem_read=1; lru_way toggled mid-miss, way_sel stays 1.
REQ-047 rst during ALLOCATE -> next cycle IDLE, pmem_read=0, counters 0.
REQ-048 Preload hit_count=32'hFFFF_FFFE, three hits -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cache_control.sv
// cache_control: write-back cache controller FSM (IDLE/COMPARE/WRITEBACK/ALLOCATE) with hit/miss counters
// Ports: clk, rst (sync, active-high); CPU side mem_read/mem_write -> mem_resp;
// datapath status hit, victim_valid, victim_dirty, lru_way; physical memory pmem_read/pmem_write/pmem_addr_sel <- pmem_resp;
// datapath controls way_sel, load_data, data_src, load_tag, set_dirty, clr_dirty, lru_update; hit_count/miss_count saturating.
module cache_control #(
  parameter int s_way = 1,
  parameter int s_index = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2**s_way-1:0] hit,
  input  logic               victim_valid,
  input  logic               victim_dirty,
  input  logic [s_way-1:0]   lru_way,
  input  logic               pmem_resp,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
  output logic [s_way-1:0]   way_sel,
  output logic               load_data,
  output logic               data_src,
  output logic               load_tag,
  output logic               set_dirty,
  output logic               clr_dirty,
  output logic               lru_update,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);
  localparam int num_way = 2**s_way;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state;
  logic [s_way-1:0] victim;
  logic [s_way-1:0] hit_way;
  logic recheck;
  logic req;
  logic chit;
  logic cwr;
  logic fill;
  logic unused_index;
  assign unused_index = ^s_index;
  assign req = mem_read | mem_write;
  always_comb begin
    hit_way = '0;
    for (int i = num_way - 1; i >= 0; i--)
      if (hit[i]) hit_way = s_way'(i);
  end
  // COMPARE outputs react to hit in the same cycle; a recheck with the request gone stays silent
  assign chit = state == COMPARE && req && |hit;
  assign cwr = chit && mem_write;
  assign fill = state == ALLOCATE && pmem_resp;
  assign mem_resp = chit;
  assign lru_update = chit;
  assign data_src = cwr;
  assign set_dirty = cwr;
  assign load_data = cwr | fill;
  assign load_tag = fill;
  assign clr_dirty = fill;
  assign pmem_read = state == ALLOCATE;
  assign pmem_write = state == WRITEBACK;
  assign pmem_addr_sel = state == WRITEBACK;
  assign way_sel = chit ? hit_way : (state == WRITEBACK || state == ALLOCATE) ? victim : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      victim <= '0;
      recheck <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: if (req) state <= COMPARE;
        COMPARE: begin
          recheck <= 1'b0;
          if (!req) state <= IDLE;
          else if (|hit) begin
            state <= IDLE;
            if (!recheck && ~&hit_count) hit_count <= hit_count + 32'd1;
          end else begin
            victim <= lru_way;
            if (~&miss_count) miss_count <= miss_count + 32'd1;
            state <= (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE: if (pmem_resp) begin
          state <= COMPARE;
          recheck <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: transaction-level self-checking bench for cache_control
module tb_cache_control;
  logic clk = 1'b0;
  logic rst, mem_read, mem_write, victim_valid, victim_dirty, pmem_resp;
  logic [1:0] hit;
  logic [0:0] lru_way, way_sel;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_data, data_src, load_tag, set_dirty, clr_dirty, lru_update;
  logic [31:0] hit_count, miss_count;
  logic [10:0] act;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_hit, exp_miss;
  localparam logic [10:0] RSP = 11'h400, PRD = 11'h200, PWR = 11'h100, ASL = 11'h080, WSL = 11'h040,
    LDD = 11'h020, DSR = 11'h010, LTG = 11'h008, SDT = 11'h004, CDT = 11'h002, LRU = 11'h001;

  cache_control #(.s_way(1), .s_index(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .lru_way(lru_way), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .way_sel(way_sel), .load_data(load_data), .data_src(data_src), .load_tag(load_tag),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty), .lru_update(lru_update),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  assign act = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, load_data, data_src, load_tag, set_dirty, clr_dirty, lru_update};

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic counters();
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  // From a missing COMPARE cycle through the fill cycle; returns the latched victim and cycles spent
  task automatic miss_path(input bit vv, input bit vd, input bit lru, input int wbw, input int fw, input bit drop,
                           output bit v, output int cycles);
    cycles = 0;
    hit = 2'b00;
    victim_valid = vv;
    victim_dirty = vd;
    lru_way = lru;
    at_neg();
    chk("cmp_miss", {21'd0, act}, 32'd0);
    exp_miss = sat(exp_miss);
    v = lru;
    cyc();
    cycles++;
    if (drop) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
    if (vv && vd)
      for (int i = 0; i <= wbw; i++) begin
        lru_way = ~lru_way;
        victim_valid = 1'($urandom);
        victim_dirty = 1'($urandom);
        pmem_resp = (i == wbw);
        at_neg();
        chk("writeback", {21'd0, act}, {21'd0, PWR | ASL | (v ? WSL : 11'd0)});
        cyc();
        cycles++;
      end
    for (int i = 0; i <= fw; i++) begin
      lru_way = ~lru_way;
      pmem_resp = (i == fw);
      at_neg();
      chk("allocate", {21'd0, act}, {21'd0, PRD | (v ? WSL : 11'd0) | ((i == fw) ? (LDD | LTG | CDT) : 11'd0)});
      cyc();
      cycles++;
    end
    pmem_resp = 1'b0;
  endtask

  // mode 0: normal, 1: request dropped mid-miss, 2: recheck misses once more
  task automatic txn(input bit wr, input logic [1:0] hv, input bit vv, input bit vd, input bit lru,
                     input int wbw, input int fw, input int mode);
    bit v;
    int c, lat;
    logic [10:0] wexp;
    wexp = wr ? (LDD | DSR | SDT) : 11'd0;
    mem_read = !wr;
    mem_write = wr;
    hit = hv;
    at_neg();
    chk("idle", {21'd0, act}, 32'd0);
    cyc();
    lat = 1;
    if (hv != 2'b00) begin
      at_neg();
      chk("hit", {21'd0, act}, {21'd0, RSP | LRU | (hv[0] ? 11'd0 : WSL) | wexp});
      exp_hit = sat(exp_hit);
    end else begin
      miss_path(vv, vd, lru, wbw, fw, mode == 1, v, c);
      lat += c;
      if (mode == 2) begin
        miss_path(1'b0, 1'b0, ~lru, 0, fw, 1'b0, v, c);
        lat += c;
      end
      hit = v ? 2'b10 : 2'b01;
      at_neg();
      chk("recheck", {21'd0, act}, (mode == 1) ? 32'd0 : {21'd0, RSP | LRU | (v ? WSL : 11'd0) | wexp});
      if (mode == 0)
        chk("latency", lat, 3 + fw + ((vv && vd) ? wbw + 1 : 0));
    end
    cyc();
    mem_read = 1'b0;
    mem_write = 1'b0;
    hit = 2'b00;
    at_neg();
    chk("back_idle", {21'd0, act}, 32'd0);
    counters();
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    hit = 2'b00;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    lru_way = 1'b0;
    pmem_resp = 1'b0;
    exp_hit = 32'd0;
    exp_miss = 32'd0;
    cyc();
    cyc();
    rst = 1'b0;
    at_neg();
    chk("reset_out", {21'd0, act}, 32'd0);
    counters();
    cyc();
    txn(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    txn(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0, 3, 0);
    txn(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1, 0);
    txn(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    txn(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1, 2, 1);
    txn(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1, 2);
    pmem_resp = 1'b1;
    txn(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    pmem_resp = 1'b0;
    for (int k = 0; k < 24; k++)
      txn(1'($urandom), ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00, 1'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    mem_read = 1'b1;
    hit = 2'b00;
    victim_valid = 1'b0;
    cyc();
    cyc();
    at_neg();
    chk("pre_rst_alloc", {21'd0, act}, {21'd0, PRD | (lru_way ? WSL : 11'd0)});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mem_read = 1'b0;
    exp_hit = 32'd0;
    exp_miss = 32'd0;
    at_neg();
    chk("rst_abort", {21'd0, act}, 32'd0);
    counters();
    cyc();
    force dut.hit_count = 32'hFFFF_FFFE;
    cyc();
    release dut.hit_count;
    exp_hit = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++)
      txn(1'($urandom), 2'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("saturated", hit_count, 32'hFFFF_FFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
